mio_responder: RTL and testbench

Memory/IO bus responder that services the load/store requests issued by the single-cycle CPU's control and datapath (request strobe, read/write select, address, write data). It decodes the address into an internal data RAM, an LED output register, a switch input port and an optional free-running counter. It completes each access with a one-cycle ready pulse after a fixed, parameterised number of wait states. It sits between the CPU core and the board I/O in the top level.

---
 rtl/mio_pkg.sv | 40 ++++
 rtl/mio_dram.sv | 22 ++
 rtl/mio_responder.sv | 142 ++++++++++++++
 tb/tb_mio_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// Shared definitions for the MIO responder: address map, FSM states and the
// access decoder used to classify each latched request.
package mio_pkg;

  localparam int          MIO_DW       = 32;
  localparam logic [3:0]  MIO_RAM_SEG  = 4'h0;
  localparam logic [31:0] MIO_SW_ADDR  = 32'hE000_0000;
  localparam logic [31:0] MIO_LED_ADDR = 32'hF000_0000;
  localparam logic [31:0] MIO_CNT_ADDR = 32'hF000_0004;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mio_state_e;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_RAM  = 3'd1,
    SEL_SW   = 3'd2,
    SEL_LED  = 3'd3,
    SEL_CNT  = 3'd4
  } mio_sel_e;

  // Partial decode: only the segment nibble and word-in-block bits matter.
  function automatic mio_sel_e mio_decode(input logic [3:0] seg, input logic [1:0] sub);
    mio_sel_e sel;
    sel = SEL_NONE;
    if (seg == MIO_RAM_SEG)
      sel = SEL_RAM;
    else if (seg == MIO_SW_ADDR[31:28] && sub == MIO_SW_ADDR[3:2])
      sel = SEL_SW;
    else if (seg == MIO_LED_ADDR[31:28] && sub == MIO_LED_ADDR[3:2])
      sel = SEL_LED;
    else if (seg == MIO_CNT_ADDR[31:28] && sub == MIO_CNT_ADDR[3:2])
      sel = SEL_CNT;
    return sel;
  endfunction

endpackage

// File: rtl/mio_dram.sv
// Single-port data RAM with synchronous read; contents are never reset.
module mio_dram
  import mio_pkg::*;
#(
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [MIO_DW-1:0] din,
  output logic [MIO_DW-1:0] dout
);

  logic [MIO_DW-1:0] mem [2**RAM_AW];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/mio_responder.sv
// Memory/IO responder for the CPU load/store bus: RAM, LEDs, switches and, when
// MIO_COUNTER_EN is defined, a free-running counter at 0xF000_0004.
module mio_responder
  import mio_pkg::*;
#(
  parameter int RAM_AW      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              mem_w,
  input  logic [31:0]       addr,
  input  logic [MIO_DW-1:0] wdata,
  input  logic [15:0]       sw_i,
  output logic              mio_ready,
  output logic [MIO_DW-1:0] rdata,
  output logic [15:0]       led_o,
  output logic              bus_err
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mio_state_e        state_reg, state_next;
  logic [3:0]        wcnt_reg, wcnt_next;
  logic              w_reg;
  mio_sel_e          sel_reg, raw_sel, dec_sel;
  logic [RAM_AW-1:0] idx_reg, ram_addr;
  logic [MIO_DW-1:0] wdata_reg, ram_dout, rd_mux, rdata_hold_reg, cnt_val;
  logic [15:0]       sw_meta_reg, sw_sync_reg, led_reg;
  logic              resp_wr, ram_we, addr_unused;

  assign addr_unused = ^addr;
  assign raw_sel     = mio_decode(addr[31:28], addr[3:2]);
  assign resp_wr     = (state_reg == RESP) && w_reg;
  assign ram_we      = resp_wr && (sel_reg == SEL_RAM);
  // The RAM sees the live address in IDLE so a zero-wait read is ready in RESP.
  assign ram_addr    = (state_reg == IDLE) ? addr[RAM_AW+1:2] : idx_reg;

`ifdef MIO_COUNTER_EN
  logic [MIO_DW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_reg <= '0;
    else if (resp_wr && sel_reg == SEL_CNT)
      cnt_reg <= wdata_reg;
    else
      cnt_reg <= cnt_reg + 32'd1;
  end

  assign cnt_val = cnt_reg;
  assign dec_sel = raw_sel;
`else
  assign cnt_val = '0;
  assign dec_sel = (raw_sel == SEL_CNT) ? SEL_NONE : raw_sel;
`endif

  mio_dram #(.RAM_AW(RAM_AW)) u_dram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (wdata_reg),
    .dout (ram_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      wcnt_reg       <= '0;
      w_reg          <= 1'b0;
      sel_reg        <= SEL_NONE;
      idx_reg        <= '0;
      wdata_reg      <= '0;
      sw_meta_reg    <= '0;
      sw_sync_reg    <= '0;
      led_reg        <= '0;
      rdata_hold_reg <= '0;
    end else begin
      state_reg   <= state_next;
      wcnt_reg    <= wcnt_next;
      sw_meta_reg <= sw_i;
      sw_sync_reg <= sw_meta_reg;
      if (state_reg == IDLE && cpu_req) begin
        w_reg     <= mem_w;
        sel_reg   <= dec_sel;
        idx_reg   <= addr[RAM_AW+1:2];
        wdata_reg <= wdata;
      end
      if (resp_wr && sel_reg == SEL_LED)
        led_reg <= wdata_reg[15:0];
      if (state_reg == RESP)
        rdata_hold_reg <= rd_mux;
    end
  end

  always_comb begin
    case (sel_reg)
      SEL_RAM: rd_mux = ram_dout;
      SEL_SW:  rd_mux = {16'h0000, sw_sync_reg};
      SEL_LED: rd_mux = {16'h0000, led_reg};
      SEL_CNT: rd_mux = cnt_val;
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    wcnt_next  = wcnt_reg;
    mio_ready  = 1'b0;
    bus_err    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cpu_req) begin
          if (WAIT_CYCLES > 0) begin
            state_next = WAIT;
            wcnt_next  = WAIT_LOAD;
          end else begin
            state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (wcnt_reg == 4'd0)
          state_next = RESP;
        else
          wcnt_next = wcnt_reg - 4'd1;
      end
      RESP: begin
        mio_ready  = 1'b1;
        bus_err    = (sel_reg == SEL_NONE);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Read data is live in RESP and then held until the next response.
  assign rdata = (state_reg == RESP) ? rd_mux : rdata_hold_reg;
  assign led_o = led_reg;

endmodule

// File: tb/tb_mio_responder.sv
// Directed scoreboard bench for mio_responder: three instances with 1, 0 and 15
// wait states share the bus inputs; each has its own request line.
`timescale 1ns/1ps
module tb_mio_responder;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_w = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [15:0] sw_i = '0;
  logic [NDUT-1:0] cpu_req = '0;
  logic [NDUT-1:0] mio_ready;
  logic [NDUT-1:0] bus_err;
  logic [31:0] rdata [NDUT];
  logic [15:0] led_o [NDUT];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rd;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rdy_seen;

  mio_responder #(.RAM_AW(10), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req[0]), .mem_w(mem_w), .addr(addr),
    .wdata(wdata), .sw_i(sw_i), .mio_ready(mio_ready[0]), .rdata(rdata[0]),
    .led_o(led_o[0]), .bus_err(bus_err[0])
  );

  mio_responder #(.RAM_AW(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req[1]), .mem_w(mem_w), .addr(addr),
    .wdata(wdata), .sw_i(sw_i), .mio_ready(mio_ready[1]), .rdata(rdata[1]),
    .led_o(led_o[1]), .bus_err(bus_err[1])
  );

  mio_responder #(.RAM_AW(10), .WAIT_CYCLES(15)) u_w15 (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req[2]), .mem_w(mem_w), .addr(addr),
    .wdata(wdata), .sw_i(sw_i), .mio_ready(mio_ready[2]), .rdata(rdata[2]),
    .led_o(led_o[2]), .bus_err(bus_err[2])
  );

  initial begin
    forever #5 clk = ~clk;
  end

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : 15;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One bus access on instance d; the expected response is queued up front and
  // popped when the ready pulse arrives. Inputs are scrambled while waiting.
  task automatic access(input string tag, input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] dat, input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    int   lat;
    bit   seen;
    e.rdata  = exp_rd;
    e.err    = exp_err;
    e.chk_rd = !w;
    e.lat    = 1 + wait_of(d);
    sb_q.push_back(e);
    @(posedge clk); #1;
    mem_w = w; addr = a; wdata = dat; cpu_req[d] = 1'b1;
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (mio_ready[d]) seen = 1'b1;
      else begin
        addr = 32'h8000_0000; wdata = ~dat; mem_w = ~w;
      end
    end
    cpu_req[d] = 1'b0;
    e = sb_q.pop_front();
    check($sformatf("%s_ready_seen", tag), 32'(seen), 32'd1);
    check($sformatf("%s_latency", tag), 32'(lat), 32'(e.lat));
    if (seen) begin
      check($sformatf("%s_bus_err", tag), 32'(bus_err[d]), 32'(e.err));
      if (e.chk_rd)
        check($sformatf("%s_rdata", tag), rdata[d], e.rdata);
      $display("txn %s dut=%0d we=%0b addr=0x%08h rdata=0x%08h err=%0b lat=%0d",
               tag, d, w, a, rdata[d], bus_err[d], lat);
      @(posedge clk); #1;
      check($sformatf("%s_ready_drop", tag), 32'(mio_ready[d]), 32'd0);
    end else begin
      $display("txn %s dut=%0d addr=0x%08h no ready within bound", tag, d, a);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("reset_ready_%0d", d), 32'(mio_ready[d]), 32'd0);
      check($sformatf("reset_bus_err_%0d", d), 32'(bus_err[d]), 32'd0);
      check($sformatf("reset_rdata_%0d", d), rdata[d], 32'd0);
      check($sformatf("reset_led_%0d", d), 32'(led_o[d]), 32'd0);
    end
    rst_n = 1'b1;

    access("ram_wr10", 0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
    access("ram_wr14", 0, 1'b1, 32'h0000_0014, 32'h1357_9BDF, 32'h0, 1'b0);
    access("ram_rd10", 0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    access("ram_rd14", 0, 1'b0, 32'h0000_0014, 32'h0, 32'h1357_9BDF, 1'b0);

    access("led_wr", 0, 1'b1, 32'hF000_0000, 32'h1234_A5A5, 32'h0, 1'b0);
    check("led_o_value", 32'(led_o[0]), 32'h0000_A5A5);
    access("led_rd", 0, 1'b0, 32'hF000_0000, 32'h0, 32'h0000_A5A5, 1'b0);

    sw_i = 16'h00F0;
    repeat (3) @(posedge clk);
    access("sw_rd", 0, 1'b0, 32'hE000_0000, 32'h0, 32'h0000_00F0, 1'b0);
    access("sw_wr", 0, 1'b1, 32'hE000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
    access("sw_rd2", 0, 1'b0, 32'hE000_0000, 32'h0, 32'h0000_00F0, 1'b0);

    access("unm_rd", 0, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b1);
    access("unm_wr", 0, 1'b1, 32'h8000_0000, 32'h5555_AAAA, 32'h0, 1'b1);
    access("unm_rd_f8", 0, 1'b0, 32'hF000_0008, 32'h0, 32'h0, 1'b1);
    access("led_rd_after_unm", 0, 1'b0, 32'hF000_0000, 32'h0, 32'h0000_A5A5, 1'b0);

    access("w0_led_wr", 1, 1'b1, 32'hF000_0000, 32'h0000_0F0F, 32'h0, 1'b0);
    access("w0_led_rd", 1, 1'b0, 32'hF000_0000, 32'h0, 32'h0000_0F0F, 1'b0);
    access("w15_led_wr", 2, 1'b1, 32'hF000_0000, 32'hABCD_7E81, 32'h0, 1'b0);
    access("w15_led_rd", 2, 1'b0, 32'hF000_0000, 32'h0, 32'h0000_7E81, 1'b0);
    check("w15_led_o", 32'(led_o[2]), 32'h0000_7E81);

`ifdef MIO_COUNTER_EN
    // Read lands 2+WAIT_CYCLES cycles after the write loads the counter.
    for (int d = 0; d < NDUT; d++) begin
      access($sformatf("cnt_wr_%0d", d), d, 1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 32'h0, 1'b0);
      access($sformatf("cnt_rd_%0d", d), d, 1'b0, 32'hF000_0004, 32'h0,
             32'hFFFF_FFFE + 32'd2 + 32'(wait_of(d)), 1'b0);
    end
`else
    access("cnt_unm_rd", 0, 1'b0, 32'hF000_0004, 32'h0, 32'h0, 1'b1);
    access("cnt_unm_wr", 0, 1'b1, 32'hF000_0004, 32'h0000_0005, 32'h0, 1'b1);
    access("cnt_unm_rd_w0", 1, 1'b0, 32'hF000_0004, 32'h0, 32'h0, 1'b1);
`endif

    access("ram20_pre", 0, 1'b1, 32'h0000_0020, 32'h1111_1111, 32'h0, 1'b0);
    @(posedge clk); #1;
    mem_w = 1'b1; addr = 32'h0000_0020; wdata = 32'h2222_2222; cpu_req[0] = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    cpu_req[0] = 1'b0;
    #1;
    check("abort_rst_ready", 32'(mio_ready[0]), 32'd0);
    check("abort_rst_bus_err", 32'(bus_err[0]), 32'd0);
    check("abort_rst_rdata", rdata[0], 32'd0);
    check("abort_rst_led", 32'(led_o[0]), 32'd0);
    rdy_seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (mio_ready[0]) rdy_seen++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (mio_ready[0]) rdy_seen++;
    end
    check("abort_no_ready", 32'(rdy_seen), 32'd0);
    $display("txn reset_abort dut=0 addr=0x00000020 ready_pulses=%0d", rdy_seen);
    access("ram20_post", 0, 1'b0, 32'h0000_0020, 32'h0, 32'h1111_1111, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
